// File: rtl/noc_packetizer_pkg.sv
// noc_packetizer shared definitions
// Flit type codes, header field layout and FSM state encoding.
package noc_packetizer_pkg;

   localparam int NOC_FLIT_W  = 16;
   localparam int NOC_COORD_W = 5;
   localparam int NOC_LEN_W   = 5;
   localparam int NOC_MAX_LEN = 16;

   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_BODY = 2'b00;

   localparam int HDR_TYPE_LSB = 14;
   localparam int HDR_LEN_LSB  = 10;
   localparam int HDR_LEN_W    = 4;
   localparam int HDR_DX_LSB   = 5;
   localparam int HDR_DY_LSB   = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   // Header: type, len-1, dest_x, dest_y; coordinates sit where
   // the router picks them up.
   function automatic logic [NOC_FLIT_W-1:0] make_header(
      input logic [NOC_COORD_W-1:0] dx,
      input logic [NOC_COORD_W-1:0] dy,
      input logic [NOC_LEN_W-1:0]   len
   );
      logic [NOC_FLIT_W-1:0] h;
      logic [HDR_LEN_W-1:0]  lm1;
      lm1 = HDR_LEN_W'(len - NOC_LEN_W'(1));
      h = '0;
      h[HDR_TYPE_LSB +: 2]          = FLIT_HEAD;
      h[HDR_LEN_LSB +: HDR_LEN_W]   = lm1;
      h[HDR_DX_LSB +: NOC_COORD_W]  = dx;
      h[HDR_DY_LSB +: NOC_COORD_W]  = dy;
      return h;
   endfunction

   // A request is legal for 1..max payload flits.
   function automatic logic len_legal(
      input logic [NOC_LEN_W-1:0] len,
      input int                   max_len
   );
      return (len != '0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/noc_packetizer.sv
// noc_packetizer: NI injection stage in front of the router
// Emits a header flit then req_len payload flits per request.
module noc_packetizer
   import noc_packetizer_pkg::*;
#(
   parameter int FLIT_W  = NOC_FLIT_W,
   parameter int COORD_W = NOC_COORD_W,
   parameter int LEN_W   = NOC_LEN_W,
   parameter int MAX_LEN = NOC_MAX_LEN
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [COORD_W-1:0] req_dest_x,
   input  logic [COORD_W-1:0] req_dest_y,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [FLIT_W-1:0]  pld_data,
   input  logic               pld_valid,
   output logic               pld_ready,
   output logic [FLIT_W-1:0]  flit_data,
   output logic               flit_valid,
   input  logic               flit_ready,
   output logic               flit_last,
   output logic               busy,
   output logic               err_len
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic [FLIT_W-1:0]   fdata_q, fdata_d;
   logic                fvalid_q, fvalid_d;
   logic                flast_q, flast_d;
   logic                err_q, err_d;

   logic                out_free;
   logic                req_fire;
   logic                pld_fire;
   logic                flit_fire;
   logic                len_ok;
   logic [FLIT_W-1:0]   header;

   // Handshake qualifiers and the header built from the request.
   always_comb begin
      out_free  = !fvalid_q || flit_ready;
      req_ready = (state_q == ST_IDLE);
      pld_ready = (state_q == ST_BODY)
                  && (remain_q != '0)
                  && out_free;
      req_fire  = req_valid && req_ready;
      pld_fire  = pld_valid && pld_ready;
      flit_fire = fvalid_q && flit_ready;
      len_ok    = len_legal(req_len, MAX_LEN);
      header    = make_header(req_dest_x, req_dest_y, req_len);
   end

   // Next state, counter and output-register loads.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      fdata_d  = fdata_q;
      fvalid_d = fvalid_q;
      flast_d  = flast_q;
      err_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (flit_fire) begin
               fvalid_d = 1'b0;
               flast_d  = 1'b0;
            end
            if (req_fire) begin
               if (len_ok) begin
                  fdata_d  = header;
                  fvalid_d = 1'b1;
                  flast_d  = 1'b0;
                  remain_d = req_len;
                  state_d  = ST_BODY;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_BODY: begin
            if (pld_fire) begin
               fdata_d  = pld_data;
               fvalid_d = 1'b1;
               flast_d  = (remain_q == LEN_W'(1));
               remain_d = remain_q - LEN_W'(1);
            end else if (flit_fire) begin
               fvalid_d = 1'b0;
               if (flast_q) begin
                  flast_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            fvalid_d = 1'b0;
            flast_d  = 1'b0;
         end
      endcase
   end

   // State and output register; reset abandons any partial packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         fdata_q  <= '0;
         fvalid_q <= 1'b0;
         flast_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         fdata_q  <= fdata_d;
         fvalid_q <= fvalid_d;
         flast_q  <= flast_d;
         err_q    <= err_d;
      end
   end

   assign flit_data  = fdata_q;
   assign flit_valid = fvalid_q;
   assign flit_last  = flast_q;
   assign busy       = (state_q != ST_IDLE);
   assign err_len    = err_q;

endmodule
